memtest_ctrl: RTL

Write/verify sequencer for the 1024 x 8 `memorymodel` RAM. On `start` it sweeps every address, writing the deterministic pattern `(2*addr) mod 256`. In verify mode it then reads every address back, compares each word and reports pass/fail, an error count and the first failing address. It sits between the top-level control logic and the memory, and owns the memory's `cs`, `wr`, `addr` and `data_in` pins while busy.

---
 rtl/memtest_pkg.sv | 25 ++
 rtl/memtest_cmp.sv | 63 ++++++
 rtl/memtest_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/memtest_pkg.sv
// Shared types, default geometry and the test-pattern function for the
// memory write/verify sequencer.
package memtest_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } memtest_state_t;

    localparam int MT_ADDR_W = 10;
    localparam int MT_DATA_W = 8;
    localparam int MT_DEPTH  = 1 << MT_ADDR_W;

    // Pattern is (2*addr) mod 2**DATA_W, optionally bit-inverted.
    function automatic logic [MT_DATA_W-1:0] mt_pattern(input logic [MT_ADDR_W-1:0] addr,
                                                         input logic inv);
        logic [MT_DATA_W-1:0] p;
        p = MT_DATA_W'(addr << 1);
        return inv ? ~p : p;
    endfunction

endpackage

// File: rtl/memtest_cmp.sv
// Read-latency pipe for expected data/address, plus comparator and
// error accumulator that records the first failing address.
module memtest_cmp
    import memtest_pkg::*;
#(
    parameter int ADDR_W = MT_ADDR_W,
    parameter int DATA_W = MT_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_exp,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              hit,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] fail_addr
);

    logic              vld_pipe  [RD_LAT];
    logic [ADDR_W-1:0] addr_pipe [RD_LAT];
    logic [DATA_W-1:0] exp_pipe  [RD_LAT];
    logic              first_seen;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_pipe[i]  <= 1'b0;
                addr_pipe[i] <= '0;
                exp_pipe[i]  <= '0;
            end
        end else begin
            vld_pipe[0]  <= rd_valid;
            addr_pipe[0] <= rd_addr;
            exp_pipe[0]  <= rd_exp;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
                exp_pipe[i]  <= exp_pipe[i-1];
            end
        end
    end

    // The last pipe slot lines up with the memory's data_out for that read.
    assign hit = vld_pipe[RD_LAT-1] && (exp_pipe[RD_LAT-1] != mem_dout);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            err_cnt    <= '0;
            fail_addr  <= '0;
            first_seen <= 1'b0;
        end else if (hit) begin
            err_cnt <= err_cnt + 1'b1;
            if (!first_seen) begin
                fail_addr  <= addr_pipe[RD_LAT-1];
                first_seen <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/memtest_ctrl.sv
// Write/verify sequencer for the 1024 x 8 RAM. Optional second inverted-pattern
// pass is enabled by defining MEMTEST_INV_PASS_EN.
module memtest_ctrl
    import memtest_pkg::*;
#(
    parameter int ADDR_W = MT_ADDR_W,
    parameter int DATA_W = MT_DATA_W,
    parameter int DEPTH  = MT_DEPTH,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic              mem_cs,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    memtest_state_t    state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n, cnt_inc;
    logic              mode_q, mode_n;
    logic              busy_n, done_n, pass_n;
    logic              cs_n, wr_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] din_n;
    logic              clear;
    logic              hit;
    logic              inv_sel;

`ifdef MEMTEST_INV_PASS_EN
    logic inv_q, inv_n;
    assign inv_sel = inv_q;
`else
    assign inv_sel = 1'b0;
`endif

    assign cnt_inc = cnt + 1'b1;

    // Every output is registered, so the next-cycle values are formed here.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mode_n  = mode_q;
        busy_n  = 1'b1;
        done_n  = 1'b0;
        pass_n  = pass;
        cs_n    = 1'b0;
        wr_n    = 1'b0;
        addr_n  = '0;
        din_n   = '0;
        clear   = 1'b0;
`ifdef MEMTEST_INV_PASS_EN
        inv_n   = inv_q;
`endif
        case (state)
            ST_IDLE: begin
                busy_n = 1'b0;
                if (start) begin
                    state_n = ST_WRITE;
                    cnt_n   = '0;
                    mode_n  = mode;
                    busy_n  = 1'b1;
                    pass_n  = 1'b0;
                    clear   = 1'b1;
                    cs_n    = 1'b1;
                    wr_n    = 1'b1;
                    din_n   = DATA_W'(mt_pattern(MT_ADDR_W'(0), 1'b0));
`ifdef MEMTEST_INV_PASS_EN
                    inv_n   = 1'b0;
`endif
                end
            end
            ST_WRITE: begin
                if (cnt == ADDR_W'(DEPTH-1)) begin
                    cnt_n = '0;
                    if (mode_q) begin
                        state_n = ST_READ;
                        cs_n    = 1'b1;
                    end else begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                        pass_n  = (err_cnt == '0) && !hit;
                    end
                end else begin
                    cnt_n  = cnt_inc;
                    cs_n   = 1'b1;
                    wr_n   = 1'b1;
                    addr_n = cnt_inc;
                    din_n  = DATA_W'(mt_pattern(MT_ADDR_W'(cnt_inc), inv_sel));
                end
            end
            ST_READ: begin
                if (cnt == ADDR_W'(DEPTH-1)) begin
                    state_n = ST_DRAIN;
                    cnt_n   = '0;
                end else begin
                    cnt_n  = cnt_inc;
                    cs_n   = 1'b1;
                    addr_n = cnt_inc;
                end
            end
            ST_DRAIN: begin
                if (cnt == ADDR_W'(RD_LAT-1)) begin
                    cnt_n = '0;
`ifdef MEMTEST_INV_PASS_EN
                    if (!inv_q) begin
                        state_n = ST_WRITE;
                        inv_n   = 1'b1;
                        cs_n    = 1'b1;
                        wr_n    = 1'b1;
                        din_n   = DATA_W'(mt_pattern(MT_ADDR_W'(0), 1'b1));
                    end else begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                        pass_n  = (err_cnt == '0) && !hit;
                    end
`else
                    state_n = ST_DONE;
                    done_n  = 1'b1;
                    pass_n  = (err_cnt == '0) && !hit;
`endif
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            mode_q   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            mem_cs   <= 1'b0;
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
`ifdef MEMTEST_INV_PASS_EN
            inv_q    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            mode_q   <= mode_n;
            busy     <= busy_n;
            done     <= done_n;
            pass     <= pass_n;
            mem_cs   <= cs_n;
            mem_wr   <= wr_n;
            mem_addr <= addr_n;
            mem_din  <= din_n;
`ifdef MEMTEST_INV_PASS_EN
            inv_q    <= inv_n;
`endif
        end
    end

    memtest_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_cmp (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .rd_valid  (mem_cs && !mem_wr),
        .rd_addr   (mem_addr),
        .rd_exp    (DATA_W'(mt_pattern(MT_ADDR_W'(mem_addr), inv_sel))),
        .mem_dout  (mem_dout),
        .hit       (hit),
        .err_cnt   (err_cnt),
        .fail_addr (fail_addr)
    );

endmodule
